mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RV32I pipeline, directly downstream of the execute-stage ALU. Consumes the EX/MEM fields produced by execute (ALU result, store data, control bits), performs byte/half/word loads and stores over a single-outstanding ready/request data-memory port, and registers the MEM/WB result for writeback. While an access is outstanding, the stage stalls upstream.

## Interface
- TIMEOUT, 16: maximum number of BUSY cycles waiting for i_dmem_ready before a bus error is declared; 0 disables the timeout.

- i_clk  in  1  clock, rising-edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  EX/MEM holds a valid instruction this cycle.
- i_alu_out  in  32  ALU result: effective address for loads and stores, otherwise the writeback value.
- i_rd2  in  32  store data (rs2).
- i_func3  in  3  access size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU. Loads accept all five; stores accept 0/1/2 only.
- i_mem_read  in  1  load.
- i_mem_write  in  1  store.
- i_reg_write  in  1  instruction writes rd.
- i_rd  in  5  destination register.
- o_stall  out  1  stage busy; upstream must hold its outputs.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_dmem_wdata  out  32  lane-replicated store data.
- o_dmem_be  out  4  byte enables.
- i_dmem_ready  in  1  request completes this cycle; load data valid.
- i_dmem_rdata  in  32  load data word.
- o_wb_valid  out  1  MEM/WB entry valid.
- o_wb_reg_write  out  1  writeback enable.
- o_wb_rd  out  5  writeback register.
- o_wb_data  out  32  writeback value.
- o_misaligned  out  1  one-cycle pulse on a misaligned access.
- o_bus_err  out  1  one-cycle pulse on a timeout.

## Operation
- FSM states:
  - IDLE: the stage accepts input.
  - BUSY: an access is outstanding.
- IDLE with i_valid and neither mem bit set:
  - Next edge loads MEM/WB: o_wb_data = i_alu_out, o_wb_reg_write = i_reg_write && (i_rd != 0).
- IDLE with i_valid and a mem bit set:
  - Check alignment first. H/HU require addr[0] = 0; W requires addr[1:0] = 0.
  - Misaligned: no request is issued. Next edge sets o_misaligned = 1, o_wb_valid = 1, o_wb_reg_write = 0, and the FSM stays in IDLE.
  - Aligned: capture address, func3, store data, rd, reg_write and we into internal registers, then go to BUSY.
- BUSY outputs:
  - o_dmem_req = 1 and o_stall = 1.
  - o_dmem_addr, o_dmem_we, o_dmem_be and o_dmem_wdata are driven from the captured registers and stay stable until completion.
- Store formatting, with lane = addr[1:0]:
  - SB: be = 1 << lane; wdata = {4{rd2[7:0]}}.
  - SH: be = 4'b0011 << lane; wdata = {2{rd2[15:0]}}.
  - SW: be = 4'b1111; wdata = rd2.
- Loads: be = 4'b1111 and we = 0.
- Load extraction:
  - Byte = rdata[8*lane +: 8]; half = rdata[8*lane +: 16].
  - LB and LH are sign-extended; LBU and LHU are zero-extended.
- Completion (BUSY with i_dmem_ready = 1 at an edge):
  - MEM/WB loads the formatted data. For a load, o_wb_reg_write = captured reg_write && rd != 0. For a store, o_wb_reg_write = 0.
  - FSM returns to IDLE.
- Timeout:
  - A BUSY cycle counter increments while i_dmem_ready = 0.
  - When TIMEOUT != 0 and the count reaches TIMEOUT, the access is abandoned. Next edge: FSM goes to IDLE, o_bus_err = 1, o_wb_valid = 1, o_wb_reg_write = 0.
- If ready and timeout coincide on the same edge, ready wins.
- If i_valid = 0 in IDLE, the next cycle has o_wb_valid = 0.
- Both mem bits set: treated as a store.
- Illegal func3 (3, 6, 7 on a load; anything other than 0/1/2 on a store) is treated as misaligned.

## Timing
- Reset values (async, while i_reset = 0):
  - FSM = IDLE, counter = 0.
  - Every output is 0: o_stall, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be, o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_misaligned, o_bus_err.
- Reset asserted mid-access drops o_dmem_req immediately and discards the access. No writeback is produced.
- Non-memory instruction: 1-cycle latency, one per cycle throughput.
- Memory access, accepted at edge N:
  - o_dmem_req is high from cycle N+1.
  - If ready is seen at edge N+k, o_wb_valid is high in cycle N+k+1, and o_stall and o_dmem_req drop in that same cycle.
  - Minimum latency is 2 cycles (ready in the first BUSY cycle).
- o_stall is a pure function of state (BUSY) and has no combinational path from i_valid.
- In IDLE, o_dmem_req = 0. The request never drops before ready or timeout.
- o_misaligned, o_bus_err and o_wb_valid are each high for exactly one cycle per event.

## Test plan
- ADD result 0x0000_1234, rd = 5, no mem op -> next cycle o_wb_valid = 1, o_wb_rd = 5, o_wb_data = 0x0000_1234, o_wb_reg_write = 1, and no request is issued.
- LB at addr 0x103 with rdata 0x80AA_BBCC, ready in the first BUSY cycle -> o_dmem_addr = 0x100, o_wb_data = 0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- SH of 0x0000_BEEF at addr 0x202, ready after 3 BUSY cycles -> be = 0b1100, wdata = 0xBEEF_BEEF, we = 1, o_stall high for 3 cycles, o_wb_reg_write = 0.
- LW at addr 0x101 -> no request, o_misaligned pulses once, o_wb_reg_write = 0. LW with rd = 0 -> o_wb_reg_write = 0.
- With TIMEOUT = 4 and ready held low -> o_dmem_req high for 4 cycles, then o_bus_err pulses and the FSM is back in IDLE. A following ADD completes normally.
- i_reset pulled low while BUSY -> o_dmem_req and o_stall go to 0 asynchronously, and no o_wb_valid follows after release.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte/half/word loads and stores over a single-outstanding
// request/ready data port, with the MEM/WB result register for writeback.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_rd2,
    input  logic [2:0]  i_func3,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ready,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_reg_write,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic [31:0] r_addr;
    logic [2:0]  r_func3;
    logic [31:0] r_sdata;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_we;

    logic        r_wb_valid, r_wb_reg_write, r_misaligned, r_bus_err;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic        w_wb_valid_nxt, w_wb_reg_write_nxt, w_mis_nxt, w_berr_nxt;
    logic [4:0]  w_wb_rd_nxt;
    logic [31:0] w_wb_data_nxt;

    logic        w_is_mem, w_bad, w_capture, w_timeout, w_busy;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data, w_wdata;
    logic [3:0]  w_be;

    assign w_is_mem  = i_mem_read | i_mem_write;
    assign w_busy    = (r_state == S_BUSY);
    assign w_timeout = (TIMEOUT != 0) && !i_dmem_ready && (r_cnt == CW'(TIMEOUT - 1));

    // Illegal sizes are folded into the misaligned path; both mem bits set counts as a store.
    always_comb begin
        w_bad = 1'b0;
        case (i_func3)
            3'd0:    w_bad = 1'b0;
            3'd1:    w_bad = i_alu_out[0];
            3'd2:    w_bad = |i_alu_out[1:0];
            3'd4:    w_bad = i_mem_write;
            3'd5:    w_bad = i_mem_write | i_alu_out[0];
            default: w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = i_dmem_rdata[7:0];
            2'd1:    w_byte = i_dmem_rdata[15:8];
            2'd2:    w_byte = i_dmem_rdata[23:16];
            default: w_byte = i_dmem_rdata[31:24];
        endcase
        w_half      = r_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        w_load_data = i_dmem_rdata;
        case (r_func3)
            3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
            3'd4:    w_load_data = {24'h000000, w_byte};
            3'd5:    w_load_data = {16'h0000, w_half};
            default: w_load_data = i_dmem_rdata;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        if (r_we) begin
            case (r_func3)
                3'd0: begin
                    w_be    = 4'b0001 << r_addr[1:0];
                    w_wdata = {4{r_sdata[7:0]}};
                end
                3'd1: begin
                    w_be    = 4'b0011 << r_addr[1:0];
                    w_wdata = {2{r_sdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = r_sdata;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_capture          = 1'b0;
        w_wb_valid_nxt     = 1'b0;
        w_wb_reg_write_nxt = 1'b0;
        w_wb_rd_nxt        = r_wb_rd;
        w_wb_data_nxt      = r_wb_data;
        w_mis_nxt          = 1'b0;
        w_berr_nxt         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    if (!w_is_mem) begin
                        w_wb_valid_nxt     = 1'b1;
                        w_wb_reg_write_nxt = i_reg_write && (i_rd != 5'd0);
                        w_wb_rd_nxt        = i_rd;
                        w_wb_data_nxt      = i_alu_out;
                    end else if (w_bad) begin
                        w_wb_valid_nxt = 1'b1;
                        w_mis_nxt      = 1'b1;
                        w_wb_rd_nxt    = i_rd;
                        w_wb_data_nxt  = i_alu_out;
                    end else begin
                        w_capture   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // Ready takes priority over a timeout landing on the same edge.
                if (i_dmem_ready) begin
                    w_state_nxt        = S_IDLE;
                    w_cnt_nxt          = '0;
                    w_wb_valid_nxt     = 1'b1;
                    w_wb_reg_write_nxt = !r_we && r_reg_write && (r_rd != 5'd0);
                    w_wb_rd_nxt        = r_rd;
                    w_wb_data_nxt      = r_we ? '0 : w_load_data;
                end else if (w_timeout) begin
                    w_state_nxt    = S_IDLE;
                    w_cnt_nxt      = '0;
                    w_wb_valid_nxt = 1'b1;
                    w_berr_nxt     = 1'b1;
                    w_wb_rd_nxt    = r_rd;
                    w_wb_data_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_addr         <= '0;
            r_func3        <= '0;
            r_sdata        <= '0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_we           <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_misaligned   <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_wb_valid     <= w_wb_valid_nxt;
            r_wb_reg_write <= w_wb_reg_write_nxt;
            r_wb_rd        <= w_wb_rd_nxt;
            r_wb_data      <= w_wb_data_nxt;
            r_misaligned   <= w_mis_nxt;
            r_bus_err      <= w_berr_nxt;
            if (w_capture) begin
                r_addr      <= i_alu_out;
                r_func3     <= i_func3;
                r_sdata     <= i_rd2;
                r_rd        <= i_rd;
                r_reg_write <= i_reg_write;
                r_we        <= i_mem_write;
            end
        end
    end

    assign o_stall        = w_busy;
    assign o_dmem_req     = w_busy;
    assign o_dmem_we      = w_busy & r_we;
    assign o_dmem_addr    = w_busy ? {r_addr[31:2], 2'b00} : '0;
    assign o_dmem_wdata   = w_busy ? w_wdata : '0;
    assign o_dmem_be      = w_busy ? w_be : '0;
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_reg_write = r_wb_reg_write;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_misaligned   = r_misaligned;
    assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB entries are queued at issue and
// compared when o_wb_valid appears.
module tb_mem_stage;

    logic        i_clk;
    logic        i_reset;
    logic        i_valid;
    logic [31:0] i_alu_out;
    logic [31:0] i_rd2;
    logic [2:0]  i_func3;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_reg_write;
    logic [4:0]  i_rd;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ready;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic        o_wb_reg_write;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_misaligned;
    logic        o_bus_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t q[$];
    exp_t e;

    mem_stage #(.TIMEOUT(4)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_valid        (i_valid),
        .i_alu_out      (i_alu_out),
        .i_rd2          (i_rd2),
        .i_func3        (i_func3),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_reg_write    (i_reg_write),
        .i_rd           (i_rd),
        .o_stall        (o_stall),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_wdata   (o_dmem_wdata),
        .o_dmem_be      (o_dmem_be),
        .i_dmem_ready   (i_dmem_ready),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_wb_valid     (o_wb_valid),
        .o_wb_reg_write (o_wb_reg_write),
        .o_wb_rd        (o_wb_rd),
        .o_wb_data      (o_wb_data),
        .o_misaligned   (o_misaligned),
        .o_bus_err      (o_bus_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic exp_t mk(input logic rw, input logic [4:0] rd, input logic [31:0] d,
                                input logic chk, input logic mis, input logic berr);
        exp_t x;
        x.rw = rw; x.rd = rd; x.data = d; x.chk = chk; x.mis = mis; x.berr = berr;
        return x;
    endfunction

    task automatic clear_in();
        i_valid = 1'b0; i_alu_out = '0; i_rd2 = '0; i_func3 = '0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_reg_write = 1'b0; i_rd = '0;
    endtask

    task automatic drive(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
        i_valid = 1'b1; i_mem_read = rd_; i_mem_write = wr_; i_func3 = f3;
        i_alu_out = addr; i_rd2 = sd; i_rd = rd; i_reg_write = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_dmem_ready = 1'b0; i_dmem_rdata = '0;
        clear_in();
        #12;
        checks++;
        if ({o_stall, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be, o_wb_valid,
             o_wb_reg_write, o_wb_rd, o_wb_data, o_misaligned, o_bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b req=%b addr=%h be=%b wbv=%b wbd=%h, want all 0",
                     o_stall, o_dmem_req, o_dmem_addr, o_dmem_be, o_wb_valid, o_wb_data);
        end
        @(negedge i_clk); i_reset = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_wb_valid !== 1'b0 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got wbv=%b stall=%b, want 0 0", o_wb_valid, o_stall);
        end
    endtask

    task automatic test_alu();
        @(negedge i_clk);
        i_valid = 1'b1; i_alu_out = 32'h0000_1234; i_rd = 5'd5; i_reg_write = 1'b1;
        q.push_back(mk(1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b0));
        @(negedge i_clk);
        clear_in();
        e = q.pop_front();
        checks++;
        if (o_wb_valid !== 1'b1 || o_wb_reg_write !== e.rw || o_wb_rd !== e.rd ||
            (e.chk && o_wb_data !== e.data) || o_misaligned !== e.mis || o_bus_err !== e.berr) begin
            errors++;
            $display("FAIL alu_wb: got v=%b rw=%b rd=%0d d=%h mis=%b be=%b, want v=1 rw=%b rd=%0d d=%h mis=%b be=%b",
                     o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_misaligned, o_bus_err,
                     e.rw, e.rd, e.data, e.mis, e.berr);
        end
        checks++;
        if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_no_req: got req=%b stall=%b, want 0 0", o_dmem_req, o_stall);
        end
        @(negedge i_clk);
        checks++;
        if (o_wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_wb_pulse: got wbv=%b, want 0", o_wb_valid);
        end
    endtask

    logic [2:0]  ld_f3[6]    = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0};
    logic [31:0] ld_addr[6]  = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h104, 32'h101};
    logic [31:0] ld_rdata[6] = '{32'h80AA_BBCC, 32'h80AA_BBCC, 32'h80AA_BBCC, 32'h1234_8001,
                                 32'hDEAD_BEEF, 32'h0000_7F00};
    logic [31:0] ld_exp[6]   = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AA, 32'h0000_8001,
                                 32'hDEAD_BEEF, 32'h0000_007F};
    logic [4:0]  ld_rd[6]    = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd0, 5'd11};

    task automatic test_load();
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            drive(1'b1, 1'b0, ld_f3[i], ld_addr[i], 32'h5555_5555, ld_rd[i]);
            q.push_back(mk(ld_rd[i] != 5'd0, ld_rd[i], ld_exp[i], 1'b1, 1'b0, 1'b0));
            @(negedge i_clk);
            clear_in();
            checks++;
            if (o_dmem_req !== 1'b1 || o_stall !== 1'b1 || o_dmem_we !== 1'b0 || o_dmem_be !== 4'hF ||
                o_dmem_addr !== {ld_addr[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL load_req[%0d]: got req=%b stall=%b we=%b be=%b addr=%h, want 1 1 0 1111 %h",
                         i, o_dmem_req, o_stall, o_dmem_we, o_dmem_be, o_dmem_addr,
                         {ld_addr[i][31:2], 2'b00});
            end
            i_dmem_ready = 1'b1; i_dmem_rdata = ld_rdata[i];
            @(negedge i_clk);
            i_dmem_ready = 1'b0;
            e = q.pop_front();
            checks++;
            if (o_wb_valid !== 1'b1 || o_wb_reg_write !== e.rw || o_wb_rd !== e.rd ||
                (e.chk && o_wb_data !== e.data) || o_misaligned !== e.mis || o_bus_err !== e.berr ||
                o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
                errors++;
                $display("FAIL load_wb[%0d]: got v=%b rw=%b rd=%0d d=%h req=%b, want v=1 rw=%b rd=%0d d=%h req=0",
                         i, o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_dmem_req, e.rw, e.rd, e.data);
            end
        end
    endtask

    logic [2:0]  st_f3[3]    = '{3'd1, 3'd0, 3'd2};
    logic [31:0] st_addr[3]  = '{32'h202, 32'h301, 32'h400};
    logic [31:0] st_data[3]  = '{32'h0000_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
    logic [3:0]  st_be[3]    = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] st_wdata[3] = '{32'hBEEF_BEEF, 32'h7878_7878, 32'hCAFE_F00D};
    int          st_wait[3]  = '{3, 1, 2};

    task automatic test_store();
        int stalls;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            drive(1'b0, 1'b1, st_f3[i], st_addr[i], st_data[i], 5'd3);
            q.push_back(mk(1'b0, 5'd3, '0, 1'b0, 1'b0, 1'b0));
            @(negedge i_clk);
            clear_in();
            stalls = 0;
            for (int c = 0; c < st_wait[i]; c++) begin
                checks++;
                if (o_dmem_req !== 1'b1 || o_dmem_we !== 1'b1 || o_dmem_be !== st_be[i] ||
                    o_dmem_wdata !== st_wdata[i] || o_dmem_addr !== {st_addr[i][31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL store_bus[%0d.%0d]: got req=%b we=%b be=%b wd=%h addr=%h, want 1 1 %b %h %h",
                             i, c, o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_wdata, o_dmem_addr,
                             st_be[i], st_wdata[i], {st_addr[i][31:2], 2'b00});
                end
                if (o_stall) stalls++;
                if (c == st_wait[i] - 1) i_dmem_ready = 1'b1;
                @(negedge i_clk);
            end
            i_dmem_ready = 1'b0;
            e = q.pop_front();
            checks++;
            if (o_wb_valid !== 1'b1 || o_wb_reg_write !== e.rw || o_wb_rd !== e.rd ||
                o_misaligned !== e.mis || o_bus_err !== e.berr || o_stall !== 1'b0) begin
                errors++;
                $display("FAIL store_wb[%0d]: got v=%b rw=%b rd=%0d stall=%b, want v=1 rw=0 rd=%0d stall=0",
                         i, o_wb_valid, o_wb_reg_write, o_wb_rd, o_stall, e.rd);
            end
            checks++;
            if (stalls != st_wait[i]) begin
                errors++;
                $display("FAIL store_stall_cycles[%0d]: got %0d, want %0d", i, stalls, st_wait[i]);
            end
        end
    endtask

    logic        mis_rd_b[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        mis_wr_b[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  mis_f3[5]   = '{3'd2, 3'd1, 3'd2, 3'd4, 3'd3};
    logic [31:0] mis_addr[5] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100};

    task automatic test_misaligned();
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            drive(mis_rd_b[i], mis_wr_b[i], mis_f3[i], mis_addr[i], 32'h1, 5'd12);
            q.push_back(mk(1'b0, 5'd12, '0, 1'b0, 1'b1, 1'b0));
            @(negedge i_clk);
            clear_in();
            e = q.pop_front();
            checks++;
            if (o_wb_valid !== 1'b1 || o_wb_reg_write !== e.rw || o_wb_rd !== e.rd ||
                o_misaligned !== e.mis || o_bus_err !== e.berr || o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
                errors++;
                $display("FAIL misaligned[%0d]: got v=%b rw=%b mis=%b req=%b stall=%b, want v=1 rw=0 mis=1 req=0 stall=0",
                         i, o_wb_valid, o_wb_reg_write, o_misaligned, o_dmem_req, o_stall);
            end
            @(negedge i_clk);
            checks++;
            if (o_misaligned !== 1'b0 || o_wb_valid !== 1'b0 || o_dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_pulse[%0d]: got mis=%b wbv=%b req=%b, want 0 0 0",
                         i, o_misaligned, o_wb_valid, o_dmem_req);
            end
        end
    endtask

    task automatic test_timeout();
        int reqs;
        @(negedge i_clk);
        drive(1'b1, 1'b0, 3'd2, 32'h500, '0, 5'd9);
        q.push_back(mk(1'b0, 5'd9, '0, 1'b0, 1'b0, 1'b1));
        @(negedge i_clk);
        clear_in();
        reqs = 0;
        for (int c = 0; c < 20 && !o_wb_valid; c++) begin
            if (o_dmem_req) reqs++;
            @(negedge i_clk);
        end
        e = q.pop_front();
        checks++;
        if (o_wb_valid !== 1'b1 || o_wb_reg_write !== e.rw || o_bus_err !== e.berr ||
            o_misaligned !== e.mis || o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wb: got v=%b rw=%b berr=%b stall=%b req=%b, want v=1 rw=0 berr=1 stall=0 req=0",
                     o_wb_valid, o_wb_reg_write, o_bus_err, o_stall, o_dmem_req);
        end
        checks++;
        if (reqs != 4) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d, want 4", reqs);
        end
        i_valid = 1'b1; i_alu_out = 32'h0000_ABCD; i_rd = 5'd6; i_reg_write = 1'b1;
        q.push_back(mk(1'b1, 5'd6, 32'h0000_ABCD, 1'b1, 1'b0, 1'b0));
        @(negedge i_clk);
        clear_in();
        e = q.pop_front();
        checks++;
        if (o_wb_valid !== 1'b1 || o_wb_reg_write !== e.rw || o_wb_rd !== e.rd ||
            o_wb_data !== e.data || o_bus_err !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout_add: got v=%b rw=%b rd=%0d d=%h berr=%b, want v=1 rw=1 rd=%0d d=%h berr=0",
                     o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_bus_err, e.rd, e.data);
        end
    endtask

    logic [31:0] b2b_val[4] = '{32'h11, 32'h2222_0000, 32'hFFFF_FFFF, 32'h0};
    logic [4:0]  b2b_rd[4]  = '{5'd1, 5'd0, 5'd31, 5'd2};

    task automatic test_back_to_back();
        for (int i = 0; i <= 4; i++) begin
            @(negedge i_clk);
            if (i > 0) begin
                e = q.pop_front();
                checks++;
                if (o_wb_valid !== 1'b1 || o_wb_reg_write !== e.rw || o_wb_rd !== e.rd ||
                    o_wb_data !== e.data || o_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got v=%b rw=%b rd=%0d d=%h, want v=1 rw=%b rd=%0d d=%h",
                             i - 1, o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, e.rw, e.rd, e.data);
                end
            end
            if (i < 4) begin
                i_valid = 1'b1; i_alu_out = b2b_val[i]; i_rd = b2b_rd[i]; i_reg_write = 1'b1;
                q.push_back(mk(b2b_rd[i] != 5'd0, b2b_rd[i], b2b_val[i], 1'b1, 1'b0, 1'b0));
            end else begin
                clear_in();
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge i_clk);
        drive(1'b1, 1'b0, 3'd2, 32'h600, '0, 5'd4);
        @(negedge i_clk);
        clear_in();
        checks++;
        if (o_dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: got req=%b, want 1", o_dmem_req);
        end
        #2 i_reset = 1'b0;
        #1;
        checks++;
        if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got req=%b stall=%b, want 0 0", o_dmem_req, o_stall);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        i_dmem_ready = 1'b1; i_dmem_rdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            checks++;
            if (o_wb_valid !== 1'b0 || o_dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_wb[%0d]: got wbv=%b req=%b, want 0 0", c, o_wb_valid, o_dmem_req);
            end
        end
        i_dmem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
